// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass,
// a per-register busy scoreboard and a post-reset clear engine.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NWR    = 2,
    parameter int NRD    = 4,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NWR-1:0]      iss_valid,
    input  logic [NWR*AW-1:0]   iss_addr,
    input  logic                flush,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    output logic                init_done
);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     clear_idx_q;
    logic              init_done_q;
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic [XLEN-1:0]   regs_q [NREGS];
    logic              ready;

    assign ready     = (state_q == S_READY);
    assign init_done = init_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_CLEAR;
            clear_idx_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_CLEAR: begin
                    clear_idx_q <= clear_idx_q + AW'(1);
                    if (clear_idx_q == AW'(NREGS - 1)) begin
                        state_q     <= S_READY;
                        init_done_q <= 1'b1;
                    end
                end
                S_READY: begin
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_CLEAR;
                    clear_idx_q <= '0;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; the clear engine zeroes it entry by entry.
    // Ports are visited high to low so the lowest-index port lands last.
    always_ff @(posedge clk) begin
        if (!ready) begin
            regs_q[clear_idx_q] <= '0;
        end else begin
            for (int k = NWR - 1; k >= 0; k--) begin
                if (wr_en[k] && (wr_addr[k*AW +: AW] != '0)) begin
                    regs_q[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Writeback clears first, then issue sets, so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        if (ready) begin
            if (flush) begin
                busy_d = '0;
            end else begin
                for (int k = 0; k < NWR; k++) begin
                    if (wr_en[k]) begin
                        busy_d[wr_addr[k*AW +: AW]] = 1'b0;
                    end
                end
                for (int k = 0; k < NWR; k++) begin
                    if (iss_valid[k]) begin
                        busy_d[iss_addr[k*AW +: AW]] = 1'b1;
                    end
                end
            end
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] val;
            ra  = rd_addr[p*AW +: AW];
            val = regs_q[ra];
            if (BYPASS != 0) begin
                for (int k = NWR - 1; k >= 0; k--) begin
                    if (wr_en[k] && (wr_addr[k*AW +: AW] == ra)) begin
                        val = wr_data[k*XLEN +: XLEN];
                    end
                end
            end
            if (ready && (ra != '0)) begin
                rd_data[p*XLEN +: XLEN] = val;
                rd_busy[p]              = busy_q[ra];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing
// instance driven in parallel from the same stimulus.
module tb_regfile_mp;

    logic         clk;
    logic         rst_n;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [63:0]  wr_data;
    logic [1:0]   iss_valid;
    logic [9:0]   iss_addr;
    logic         flush;
    logic [19:0]  rd_addr;
    logic [127:0] rd_data1;
    logic [127:0] rd_data0;
    logic [3:0]   rd_busy1;
    logic [3:0]   rd_busy0;
    logic         done1;
    logic         done0;

    int vectors;
    int miscompares;

    regfile_mp #(.BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush),
        .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
        .init_done(done1)
    );

    regfile_mp #(.BYPASS(0)) u_nobyp (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush),
        .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
        .init_done(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en     = '0;
        iss_valid = '0;
        flush     = 1'b0;
    endtask

    task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d);
        wr_en[k]          = 1'b1;
        wr_addr[k*5 +: 5]  = a;
        wr_data[k*32 +: 32] = d;
    endtask

    task automatic iss(input int k, input logic [4:0] a);
        iss_valid[k]       = 1'b1;
        iss_addr[k*5 +: 5] = a;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        rd_addr[p*5 +: 5] = a;
    endtask

    function automatic logic [31:0] d1(input int p);
        return rd_data1[p*32 +: 32];
    endfunction

    function automatic logic [31:0] d0(input int p);
        return rd_data0[p*32 +: 32];
    endfunction

    function automatic logic [31:0] b1(input int p);
        return {31'b0, rd_busy1[p]};
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        iss_addr    = '0;
        rd_addr     = '0;
        idle();
        #1;
        chk("rst_init_done", {31'b0, done1}, 32'd0);
        chk("rst_busy", {28'b0, rd_busy1}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Writes and issues during CLEAR must be ignored.
        wr(0, 5'd5, 32'hDEADBEEF);
        iss(1, 5'd5);
        rd(0, 5'd5);
        for (int i = 0; i < 32; i++) begin
            #1;
            chk("clear_init_done", {31'b0, done1}, 32'd0);
            chk("clear_rd_zero", d1(0), 32'd0);
            tick();
        end
        idle();
        #1;
        chk("init_done_high", {31'b0, done1}, 32'd1);
        chk("init_done_nobyp", {31'b0, done0}, 32'd1);
        chk("x5_after_clear", d1(0), 32'd0);
        chk("x5_busy_after_clear", b1(0), 32'd0);
        rd(1, 5'd1);
        rd(2, 5'd17);
        rd(3, 5'd31);
        #1;
        chk("x1_zero", d1(1), 32'd0);
        chk("x17_zero", d1(2), 32'd0);
        chk("x31_zero", d1(3), 32'd0);

        // Same-address conflict: port 0 wins.
        wr(0, 5'd3, 32'h11111111);
        wr(1, 5'd3, 32'h22222222);
        rd(0, 5'd3);
        #1;
        chk("conflict_bypass", d1(0), 32'h11111111);
        tick();
        idle();
        #1;
        chk("conflict_byp", d1(0), 32'h11111111);
        chk("conflict_nobyp", d0(0), 32'h11111111);

        wr(0, 5'd4, 32'h0000000A);
        wr(1, 5'd0, 32'h0000000B);
        tick();
        idle();
        rd(0, 5'd4);
        rd(1, 5'd0);
        #1;
        chk("x4_written", d0(0), 32'h0000000A);
        chk("x0_discard", d0(1), 32'd0);
        chk("x0_discard_byp", d1(1), 32'd0);

        // Bypass versus registered-only read.
        wr(1, 5'd7, 32'h12345678);
        rd(2, 5'd7);
        #1;
        chk("bypass_same_cycle", d1(2), 32'h12345678);
        chk("nobypass_old", d0(2), 32'd0);
        tick();
        idle();
        #1;
        chk("nobypass_next", d0(2), 32'h12345678);

        // Scoreboard set, clear, and issue-beats-writeback.
        iss(0, 5'd9);
        rd(0, 5'd9);
        tick();
        idle();
        #1;
        chk("busy_set", b1(0), 32'd1);
        wr(0, 5'd9, 32'h00000099);
        #1;
        chk("busy_no_bypass", b1(0), 32'd1);
        chk("busy_wb_data_byp", d1(0), 32'h00000099);
        tick();
        idle();
        #1;
        chk("busy_cleared", b1(0), 32'd0);
        wr(0, 5'd9, 32'h0000009A);
        iss(1, 5'd9);
        tick();
        idle();
        #1;
        chk("issue_beats_wb", b1(0), 32'd1);
        iss(0, 5'd0);
        rd(1, 5'd0);
        tick();
        idle();
        #1;
        chk("x0_never_busy", b1(1), 32'd0);

        // Flush clears everything, including a same-cycle issue.
        iss(0, 5'd1);
        iss(1, 5'd2);
        tick();
        idle();
        iss(0, 5'd31);
        tick();
        idle();
        rd(0, 5'd1);
        rd(1, 5'd2);
        rd(2, 5'd31);
        rd(3, 5'd9);
        #1;
        chk("busy_x1", b1(0), 32'd1);
        chk("busy_x2", b1(1), 32'd1);
        chk("busy_x31", b1(2), 32'd1);
        chk("busy_x9", b1(3), 32'd1);
        flush = 1'b1;
        iss(0, 5'd6);
        tick();
        idle();
        rd(3, 5'd6);
        #1;
        chk("flush_busy", {28'b0, rd_busy1}, 32'd0);
        chk("flush_busy_nobyp", {28'b0, rd_busy0}, 32'd0);

        // Asynchronous reset in READY restarts the clear sequence.
        wr(0, 5'd10, 32'h5A5A5A5A);
        tick();
        idle();
        rd(0, 5'd10);
        rd(1, 5'd3);
        #1;
        chk("x10_written", d0(0), 32'h5A5A5A5A);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_drop", {31'b0, done1}, 32'd0);
        chk("reset_rd_zero", d1(0), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            chk("reclear_init_done", {31'b0, done0}, 32'd0);
            tick();
        end
        #1;
        chk("reinit_done", {31'b0, done0}, 32'd1);
        chk("x10_cleared", d0(0), 32'd0);
        chk("x3_cleared", d1(1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
